// File: rtl/rsv_pkg.sv
// Shared definitions for the rsv decode-stage demux scheduler.
// Holds the port count, the select width, the FSM state type and the
// lowest illegal destination value.
package rsv_pkg;

  localparam int NUM_PORTS = 6;
  localparam int SEL_W     = 3;

  // Destinations at or above this value have no demux output.
  localparam logic [SEL_W-1:0] ILLEGAL_DEST = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/rsv_credit_cnt.sv
// Single-port credit counter: saturating up/down, reset to CREDITS.
// Latency: count updates on the edge after dec/inc; nonzero is combinational from count.
// Backpressure: none here; the scheduler gates dec with nonzero so it never underflows.
// Ports: clk, reset (sync, active-high), dec (credit consumed), inc (credit returned),
//        count (current credits), nonzero (count > 0).
module rsv_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          nonzero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CW'(CREDITS);
    end else if (inc && !dec) begin
      // A return at full count is held at full count.
      if (count != CW'(CREDITS)) count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CW'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/rsv_demux_sched.sv
// Scheduler for the 1-to-6 rsv output demux: locks each packet to a port, tracks credits.
// Latency: 1 cycle from acceptance to registered out_valid/out_sel/out_data.
// Backpressure: in_ready drops when the target port has no credit; illegal packets always drain.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_head/in_tail/in_dest/in_data
//        upstream flits; out_valid/out_sel/out_data to the demux; credit_ret per-port returns;
//        busy while a packet is open. Optional macro RSV_SCHED_ERR_EN adds err_flags, err_cnt.
module rsv_demux_sched
  import rsv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_head,
  input  logic                 in_tail,
  input  logic [SEL_W-1:0]     in_dest,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_sel,
  output logic [WIDTH-1:0]     out_data,
  input  logic [NUM_PORTS-1:0] credit_ret,
  output logic                 busy
`ifdef RSV_SCHED_ERR_EN
  ,
  output logic [1:0]           err_flags,
  output logic [7:0]           err_cnt
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     lock_port, lock_nxt;
  logic                 accept;
  logic                 issue;
  logic [SEL_W-1:0]     issue_port;
  logic                 dest_ok;
  logic [NUM_PORTS-1:0] cred_nz;
  logic [NUM_PORTS-1:0] cred_dec;
  logic [NUM_PORTS-1:0] sat_ret;
  logic [CW-1:0]        cred_cnt [NUM_PORTS];

  assign dest_ok = (in_dest < ILLEGAL_DEST);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cred
    assign cred_dec[k] = issue && (issue_port == SEL_W'(k));
    // Return with no matching issue while full: the counter clips it.
    assign sat_ret[k]  = credit_ret[k] && !cred_dec[k] && (cred_cnt[k] == CW'(CREDITS));

    rsv_credit_cnt #(
      .CREDITS (CREDITS),
      .CW      (CW)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .dec     (cred_dec[k]),
      .inc     (credit_ret[k]),
      .count   (cred_cnt[k]),
      .nonzero (cred_nz[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_port <= '0;
    end else begin
      state     <= state_nxt;
      lock_port <= lock_nxt;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_port = lock_port;
    state_nxt  = state;
    lock_nxt   = lock_port;

    unique case (state)
      // in_dest only matters on a head; stray body flits and illegal heads always drain.
      IDLE:    in_ready = (!in_head || !dest_ok) ? 1'b1 : cred_nz[in_dest];
      FWD:     in_ready = cred_nz[lock_port];
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;

    accept = in_valid && in_ready;

    if (accept) begin
      unique case (state)
        IDLE: begin
          if (in_head && dest_ok) begin
            issue      = 1'b1;
            issue_port = in_dest;
            if (!in_tail) begin
              state_nxt = FWD;
              lock_nxt  = in_dest;
            end
          end else if (in_head) begin
            if (!in_tail) state_nxt = DROP;
          end
        end
        FWD: begin
          issue      = 1'b1;
          issue_port = lock_port;
          if (in_tail) state_nxt = IDLE;
        end
        DROP: begin
          if (in_tail) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // out_sel/out_data hold their last issued values across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_sel  <= issue_port;
        out_data <= in_data;
      end
    end
  end

  assign busy = (state != IDLE);

  sat_ret_a: assert property (@(posedge clk) disable iff (reset) sat_ret == '0)
    else $error("credit return to a port already at full credit");

`ifdef RSV_SCHED_ERR_EN
  logic drop;
  logic bad_dest;
  logic stray_body;

  assign drop       = accept && !issue;
  assign bad_dest   = accept && (state == IDLE) && in_head && !dest_ok;
  assign stray_body = accept && (state == IDLE) && !in_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_flags <= 2'b00;
      err_cnt   <= 8'd0;
    end else begin
      if (bad_dest) err_flags[0] <= 1'b1;
      if (stray_body || (sat_ret != '0)) err_flags[1] <= 1'b1;
      if (drop && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
